// File: rtl/ifetch.sv
// ifetch - instruction fetch unit between the PC unit and instruction memory.
//
// Reads the current pc, issues one outstanding read at a time to instruction
// memory over a req/ack handshake, and parks returned words in a 2-entry
// buffer. pc_en pulses once per accepted instruction so the PC unit advances.
// The buffer head is presented to decode with its fields already split out.
//
// Ports:
//   clock       in   1   system clock, rising-edge active
//   reset       in   1   asynchronous, active-low reset
//   pc          in  32   address of next instruction (from PC unit)
//   pc_en       out  1   advance strobe to PC unit
//   flush       in   1   redirect; PC loads a non-sequential target this edge
//   imem_req    out  1   read request, held until ack
//   imem_addr   out 32   request address, stable while imem_req=1
//   imem_ack    in   1   read data valid this cycle
//   imem_rdata  in  32   instruction word, valid with imem_ack
//   inst_valid  out  1   buffer non-empty
//   inst_ready  in   1   decode accepts the head entry
//   inst        out 32   head instruction word
//   inst_pc     out 32   address the head instruction came from
//   opcode      out  6   inst[31:26]
//   rc          out  5   inst[25:21]
//   ra          out  5   inst[20:16]
//   rb          out  5   inst[15:11]
//   id          out 16   inst[15:0], literal for the branch-offset path
module ifetch #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_en,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [5:0]  opcode,
  output logic [4:0]  rc,
  output logic [4:0]  ra,
  output logic [4:0]  rb,
  output logic [15:0] id
);

  // The buffer is fixed at two entries, so pointers are one bit and wrap
  // naturally; the count needs to represent 0..2.
  localparam int PTR_W = 1;
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ADV,
    DROP
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic             w_push;
  logic             w_pop;
  logic             w_issue;

  logic             r_req;
  logic [31:0]      r_addr;

  logic [31:0]      r_inst [DEPTH];
  logic [31:0]      r_pc   [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A new fetch only starts with room guaranteed for its result (count<=1),
  // which is what makes push-while-full unreachable. A flush during an
  // outstanding request never cancels the handshake: the request is parked
  // in DROP until memory answers and the word is thrown away.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (!flush && (r_count != FULL)) begin
          w_next = REQ;
        end
      end
      REQ: begin
        if (imem_ack) begin
          w_next = flush ? IDLE : ADV;
        end else if (flush) begin
          w_next = DROP;
        end
      end
      ADV: begin
        w_next = IDLE;
      end
      DROP: begin
        if (imem_ack) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // pc_en is suppressed by a same-cycle flush so the PC unit loads the
  // redirect target instead of pc+4.
  always_comb begin
    pc_en   = (r_state == ADV) && !flush;
    w_push  = (r_state == REQ) && imem_ack && !flush;
    w_issue = (r_state == IDLE) && (w_next == REQ);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_req  <= 1'b0;
      r_addr <= '0;
    end else begin
      r_req <= (w_next == REQ) || (w_next == DROP);
      if (w_issue) begin
        r_addr <= pc;
      end
    end
  end

  assign w_pop = (r_count != '0) && inst_ready;

  // Flush wins over any same-cycle push or pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_inst[i] <= '0;
        r_pc[i]   <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_inst[r_wptr] <= imem_rdata;
        r_pc[r_wptr]   <= r_addr;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_noOverflow: assert property (@(posedge clock) disable iff (!reset)
    !(w_push && (r_count == FULL)));

  assign imem_req   = r_req;
  assign imem_addr  = r_addr;
  assign inst_valid = (r_count != '0);

  // Head outputs are forced to zero while empty so stale entries never leak.
  assign inst    = inst_valid ? r_inst[r_rptr] : '0;
  assign inst_pc = inst_valid ? r_pc[r_rptr] : '0;
  assign opcode  = inst[31:26];
  assign rc      = inst[25:21];
  assign ra      = inst[20:16];
  assign rb      = inst[15:11];
  assign id      = inst[15:0];

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch - self-checking bench for ifetch.
//
// Drives a simple PC unit (pc+4 on pc_en, target on flush) and an instruction
// memory that answers addr^0xA5A5A5A5 after a configurable number of wait
// states. A transaction-level model (buffer as a queue, one outstanding
// fetch tracked as a record) predicts every output each cycle. Directed
// tables and sequences pin the documented cycle timing.
module tb_ifetch;

  logic        clock;
  logic        reset;
  logic [31:0] pc;
  logic        pc_en;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [5:0]  opcode;
  logic [4:0]  rc;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [15:0] id;

  ifetch #(.DEPTH(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .pc         (pc),
    .pc_en      (pc_en),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .opcode     (opcode),
    .rc         (rc),
    .ra         (ra),
    .rb         (rb),
    .id         (id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // memory model state
  int          memWait;
  int          waitLeft;
  bit          memBusy;
  bit          randWaits;
  int          randWaitMax;
  logic [31:0] flushTarget;

  // reference model: buffer contents plus the one fetch in flight
  logic [31:0] mqInst[$];
  logic [31:0] mqPc[$];
  bit          mOut;
  bit          mDoomed;
  bit          mJust;
  logic [31:0] mAddr;

  typedef struct {
    logic        flush;
    logic        ready;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expPcEn;
    logic        expValid;
    logic [31:0] expInstPc;
  } vecT;

  vecT vecs[$];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic addVec(input logic f, input logic r, input logic eReq, input logic [31:0] eAddr,
                        input logic ePe, input logic eV, input logic [31:0] eIp);
    vecT v;
    v.flush     = f;
    v.ready     = r;
    v.expReq    = eReq;
    v.expAddr   = eAddr;
    v.expPcEn   = ePe;
    v.expValid  = eV;
    v.expInstPc = eIp;
    vecs.push_back(v);
  endtask

  task automatic modelReset();
    mqInst.delete();
    mqPc.delete();
    mOut    = 1'b0;
    mDoomed = 1'b0;
    mJust   = 1'b0;
    mAddr   = '0;
    memBusy = 1'b0;
  endtask

  // Instruction memory: answers after the chosen number of wait states.
  task automatic memDrive();
    if (imem_req === 1'b1) begin
      if (!memBusy) begin
        memBusy  = 1'b1;
        waitLeft = randWaits ? int'($urandom_range(randWaitMax, 0)) : memWait;
      end
      imem_ack   = (waitLeft == 0);
      imem_rdata = imem_addr ^ 32'hA5A5A5A5;
      if (waitLeft > 0) waitLeft--;
      else memBusy = 1'b0;
    end else begin
      memBusy    = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
    end
  endtask

  // Called just after a rising edge: drive this cycle's inputs, let outputs settle.
  task automatic applyStimulus(input logic f, input logic rdy, input logic [31:0] tgt);
    flush       = f;
    flushTarget = tgt;
    inst_ready  = rdy;
    memDrive();
    #1;
  endtask

  task automatic checkOutput();
    logic [31:0] expI;
    checkVal("imem_req", imem_req, mOut);
    if (mOut) checkVal("imem_addr", imem_addr, mAddr);
    checkVal("pc_en", pc_en, mJust && !flush);
    checkVal("inst_valid", inst_valid, mqInst.size() > 0);
    if (mqInst.size() > 0) begin
      expI = mqInst[0];
      checkVal("inst", inst, expI);
      checkVal("inst_pc", inst_pc, mqPc[0]);
      checkVal("opcode", opcode, expI[31:26]);
      checkVal("rc", rc, expI[25:21]);
      checkVal("ra", ra, expI[20:16]);
      checkVal("rb", rb, expI[15:11]);
      checkVal("id", id, expI[15:0]);
    end
  endtask

  // Model update for the coming edge, from the rules for a single fetch.
  task automatic modelAdvance();
    bit idle;
    bit accept;
    int sizeBefore;
    idle       = !mOut && !mJust;
    sizeBefore = mqInst.size();
    accept     = mOut && (imem_ack === 1'b1) && !mDoomed && !flush;
    if (flush) begin
      mqInst.delete();
      mqPc.delete();
    end else begin
      if (inst_ready && sizeBefore > 0) begin
        void'(mqInst.pop_front());
        void'(mqPc.pop_front());
      end
      if (accept) begin
        mqInst.push_back(mAddr ^ 32'hA5A5A5A5);
        mqPc.push_back(mAddr);
      end
    end
    if (mOut) begin
      if (imem_ack === 1'b1) mOut = 1'b0;
      else if (flush) mDoomed = 1'b1;
    end else if (idle && !flush && sizeBefore <= 1) begin
      mOut    = 1'b1;
      mAddr   = pc;
      mDoomed = 1'b0;
    end
    mJust = accept;
  endtask

  task automatic endCycle();
    logic [31:0] nxt;
    nxt = flush ? flushTarget : ((pc_en === 1'b1) ? pc + 32'd4 : pc);
    modelAdvance();
    @(posedge clock);
    #1;
    pc = nxt;
  endtask

  task automatic runCycle(input logic f, input logic rdy, input logic [31:0] tgt);
    applyStimulus(f, rdy, tgt);
    checkOutput();
    endCycle();
  endtask

  // Leaves the bench just after reset release, mid-cycle, ahead of the first edge.
  task automatic doReset(input logic [31:0] pcInit);
    reset      = 1'b0;
    flush      = 1'b0;
    imem_ack   = 1'b0;
    inst_ready = 1'b0;
    pc         = pcInit;
    modelReset();
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    pc          = '0;
    flush       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    inst_ready  = 1'b0;
    memWait     = 0;
    waitLeft    = 0;
    randWaits   = 1'b0;
    randWaitMax = 3;
    flushTarget = '0;
    modelReset();

    // reset held with random inputs: every output stays zero
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      pc         = $urandom;
      flush      = 1'($urandom);
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
      inst_ready = 1'($urandom);
      #2;
      checkVal("rst_imem_req", imem_req, 0);
      checkVal("rst_imem_addr", imem_addr, 0);
      checkVal("rst_pc_en", pc_en, 0);
      checkVal("rst_inst_valid", inst_valid, 0);
      checkVal("rst_inst", inst, 0);
      checkVal("rst_inst_pc", inst_pc, 0);
      checkVal("rst_fields", {opcode, rc, ra, rb}, 0);
      checkVal("rst_id", id, 0);
    end
    @(negedge clock);
    pc         = 32'h80000000;
    flush      = 1'b0;
    imem_ack   = 1'b0;
    inst_ready = 1'b1;
    reset      = 1'b1;
    @(posedge clock);
    #1;
    checkVal("rel_imem_req", imem_req, 1);
    checkVal("rel_imem_addr", imem_addr, 32'h80000000);

    // streaming then backpressure, zero-wait memory, one row per cycle
    addVec(0, 1, 1, 32'd0,  0, 0, 0);
    addVec(0, 1, 0, 0,      1, 1, 32'd0);
    addVec(0, 1, 0, 0,      0, 0, 0);
    addVec(0, 1, 1, 32'd4,  0, 0, 0);
    addVec(0, 1, 0, 0,      1, 1, 32'd4);
    addVec(0, 1, 0, 0,      0, 0, 0);
    addVec(0, 1, 1, 32'd8,  0, 0, 0);
    addVec(0, 1, 0, 0,      1, 1, 32'd8);
    addVec(0, 1, 0, 0,      0, 0, 0);
    addVec(0, 1, 1, 32'd12, 0, 0, 0);
    addVec(0, 1, 0, 0,      1, 1, 32'd12);
    addVec(0, 1, 0, 0,      0, 0, 0);
    addVec(0, 0, 1, 32'd16, 0, 0, 0);
    addVec(0, 0, 0, 0,      1, 1, 32'd16);
    addVec(0, 0, 0, 0,      0, 1, 32'd16);
    addVec(0, 0, 1, 32'd20, 0, 1, 32'd16);
    addVec(0, 0, 0, 0,      1, 1, 32'd16);
    addVec(0, 0, 0, 0,      0, 1, 32'd16);
    addVec(0, 0, 0, 0,      0, 1, 32'd16);
    addVec(0, 1, 0, 0,      0, 1, 32'd16);
    addVec(0, 0, 0, 0,      0, 1, 32'd20);
    addVec(0, 0, 1, 32'd24, 0, 1, 32'd20);
    addVec(0, 0, 0, 0,      1, 1, 32'd20);
    addVec(0, 0, 0, 0,      0, 1, 32'd20);
    addVec(0, 0, 0, 0,      0, 1, 32'd20);

    $display("[TB] streaming / backpressure table");
    memWait = 0;
    doReset(32'h0);
    runCycle(0, 1, 0);
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].flush, vecs[k].ready, 0);
      checkVal($sformatf("vec%0d_req", k), imem_req, vecs[k].expReq);
      if (vecs[k].expReq) checkVal($sformatf("vec%0d_addr", k), imem_addr, vecs[k].expAddr);
      checkVal($sformatf("vec%0d_pc_en", k), pc_en, vecs[k].expPcEn);
      checkVal($sformatf("vec%0d_valid", k), inst_valid, vecs[k].expValid);
      if (vecs[k].expValid) checkVal($sformatf("vec%0d_inst_pc", k), inst_pc, vecs[k].expInstPc);
      checkOutput();
      endCycle();
    end

    $display("[TB] flush with memory stalled");
    memWait = 3;
    doReset(32'h40);
    runCycle(0, 1, 0);
    runCycle(0, 1, 0);
    applyStimulus(1, 1, 32'h100);
    checkOutput();
    checkVal("stall_req", imem_req, 1);
    endCycle();
    applyStimulus(0, 1, 0);
    checkOutput();
    checkVal("drop_req_w", imem_req, 1);
    checkVal("drop_addr_w", imem_addr, 32'h40);
    checkVal("drop_pc_en_w", pc_en, 0);
    endCycle();
    applyStimulus(0, 1, 0);
    checkOutput();
    checkVal("drop_addr_ack", imem_addr, 32'h40);
    checkVal("drop_pc_en_ack", pc_en, 0);
    endCycle();
    applyStimulus(0, 1, 0);
    checkOutput();
    checkVal("drop_after_req", imem_req, 0);
    checkVal("drop_after_valid", inst_valid, 0);
    checkVal("drop_after_pc_en", pc_en, 0);
    endCycle();
    applyStimulus(0, 1, 0);
    checkOutput();
    checkVal("redirect_req", imem_req, 1);
    checkVal("redirect_addr", imem_addr, 32'h100);
    endCycle();

    $display("[TB] flush coincident with ack and during advance");
    memWait = 0;
    doReset(32'h200);
    runCycle(0, 1, 0);
    applyStimulus(1, 1, 32'h300);
    checkOutput();
    checkVal("coin_pc_en", pc_en, 0);
    endCycle();
    applyStimulus(0, 1, 0);
    checkOutput();
    checkVal("coin_idle_req", imem_req, 0);
    checkVal("coin_idle_valid", inst_valid, 0);
    endCycle();
    applyStimulus(0, 1, 0);
    checkOutput();
    checkVal("coin_next_addr", imem_addr, 32'h300);
    endCycle();
    applyStimulus(1, 1, 32'h400);
    checkOutput();
    checkVal("adv_flush_pc_en", pc_en, 0);
    checkVal("adv_flush_valid", inst_valid, 1);
    endCycle();
    applyStimulus(0, 1, 0);
    checkOutput();
    checkVal("adv_flush_cleared", inst_valid, 0);
    endCycle();
    applyStimulus(0, 1, 0);
    checkOutput();
    checkVal("adv_flush_next_addr", imem_addr, 32'h400);
    endCycle();

    $display("[TB] async reset mid-request");
    memWait = 2;
    doReset(32'h500);
    for (int i = 0; i < 6; i++) runCycle(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput();
    checkVal("pre_arst_req", imem_req, 1);
    checkVal("pre_arst_valid", inst_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    checkVal("arst_req", imem_req, 0);
    checkVal("arst_valid", inst_valid, 0);
    checkVal("arst_inst", inst, 0);
    imem_ack = 1'b0;
    modelReset();
    @(posedge clock);
    #1;
    pc = 32'h600;
    @(negedge clock);
    reset = 1'b1;
    runCycle(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput();
    checkVal("arst_restart_addr", imem_addr, 32'h600);
    endCycle();

    $display("[TB] randomized traffic");
    randWaits = 1'b1;
    doReset($urandom & 32'hFFFFFFFC);
    for (int i = 0; i < 3000; i++) begin
      runCycle(1'($urandom_range(99, 0) < 8), 1'($urandom_range(99, 0) < 60),
               $urandom & 32'hFFFFFFFC);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
